mem_arbiter: RTL

Sequential arbiter sharing the core's single-port instruction/data memory between the instruction-fetch unit and the load/store unit inside `core`. It accepts one request at a time, drives it onto the memory port with a valid/ready handshake, waits for the memory response and routes it back to the owning requester. Only one transaction is outstanding at any time.

---
 rtl/tinyv_mem_pkg.sv | 30 +++
 rtl/mem_arb_grant.sv | 51 +++++
 rtl/mem_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/tinyv_mem_pkg.sv
// Shared types and widths for the core memory arbiter.
package tinyv_mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = MEM_DATA_W / 8;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_IF = 0;
  localparam int GNT_LS = 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } mem_arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } mem_owner_e;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic                  we;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_BE_W-1:0]   be;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_grant.sv
// One-hot grant between fetch and load/store, only while the arbiter is idle.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin on ties; otherwise ls always wins.
module mem_arb_grant
  import tinyv_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       if_valid,
  input  logic       ls_valid,
  input  logic       idle,
  output logic [1:0] grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  mem_owner_e last_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= OWN_IF;
    end else if (|grant) begin
      last_grant <= grant[GNT_LS] ? OWN_LS : OWN_IF;
    end
  end

  always_comb begin
    grant = '0;
    if (idle) begin
      if (if_valid && ls_valid) begin
        if (last_grant == OWN_IF) grant[GNT_LS] = 1'b1;
        else                      grant[GNT_IF] = 1'b1;
      end else begin
        grant[GNT_LS] = ls_valid;
        grant[GNT_IF] = if_valid;
      end
    end
  end
`else
  // Fixed priority keeps no history, so the clock and reset go unused here.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ reset;

  always_comb begin
    grant = '0;
    if (idle) begin
      if (ls_valid)      grant[GNT_LS] = 1'b1;
      else if (if_valid) grant[GNT_IF] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Sequential arbiter sharing the single-port memory between fetch and load/store.
// Grant policy: fixed ls > if, or round-robin when MEM_ARB_ROUND_ROBIN_EN is defined.
//
// state | meaning
// IDLE  | no transaction open; grant one requester and latch its request
// REQ   | mem_req_valid high with latched fields until mem_req_ready
// WAIT  | waiting for mem_rsp_valid; response goes to the owner next cycle
module mem_arbiter
  import tinyv_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_rdata,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_we,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_be,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rsp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_we,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_be,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_rdata
);

  mem_arb_state_e state, state_next;
  mem_owner_e     owner;
  mem_req_t       req_q;
  logic [1:0]     grant;
  logic           idle;
  logic           rsp_fire;

  // Gating with reset keeps ready low while the latch is held in reset.
  assign idle     = (state == IDLE) && !reset;
  assign rsp_fire = (state == WAIT) && mem_rsp_valid;

  mem_arb_grant u_grant (
    .clk      (clk),
    .reset    (reset),
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .idle     (idle),
    .grant    (grant)
  );

  assign if_req_ready  = grant[GNT_IF];
  assign ls_req_ready  = grant[GNT_LS];
  assign mem_req_valid = (state == REQ);
  assign mem_req_addr  = req_q.addr;
  assign mem_req_we    = req_q.we;
  assign mem_req_wdata = req_q.wdata;
  assign mem_req_be    = req_q.be;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|grant)        state_next = REQ;
      REQ:     if (mem_req_ready) state_next = WAIT;
      WAIT:    if (mem_rsp_valid) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q        <= '0;
      owner        <= OWN_IF;
      if_rsp_valid <= 1'b0;
      if_rsp_rdata <= '0;
      ls_rsp_valid <= 1'b0;
      ls_rsp_rdata <= '0;
    end else begin
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      if (grant[GNT_LS]) begin
        req_q <= '{addr: ls_req_addr, we: ls_req_we, wdata: ls_req_wdata, be: ls_req_be};
        owner <= OWN_LS;
      end else if (grant[GNT_IF]) begin
        req_q <= '{addr: if_req_addr, we: 1'b0, wdata: '0, be: '0};
        owner <= OWN_IF;
      end
      if (rsp_fire) begin
        if (owner == OWN_LS) begin
          ls_rsp_valid <= 1'b1;
          ls_rsp_rdata <= req_q.we ? '0 : mem_rsp_rdata;
        end else begin
          if_rsp_valid <= 1'b1;
          if_rsp_rdata <= mem_rsp_rdata;
        end
      end
    end
  end

endmodule
